// File: rtl/mms_stream_sel.sv
// mms_stream_sel: streaming frame max/min selector.
// One shared comparator; registered valid/ready result port.
module mms_stream_sel #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       result_idx,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [7:0]       res_idx_q, res_idx_d;
  logic             ovalid_q, ovalid_d;

  logic             accept;
  logic             wins;
  logic [WIDTH-1:0] win_data;
  logic [7:0]       win_idx;

  assign in_ready = (state_q != DONE);
  assign accept   = in_valid && in_ready;

  // Strict compare: ties keep the earlier (lower-index) word.
  assign wins     = sel_q ? (in_data < acc_q) : (in_data > acc_q);
  assign win_data = wins ? in_data : acc_q;
  assign win_idx  = wins ? cnt_q : idx_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    res_d     = res_q;
    res_idx_d = res_idx_q;
    ovalid_d  = ovalid_q;
    if (clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      ovalid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sel_d   = select;
            acc_d   = in_data;
            idx_d   = '0;
            cnt_d   = 8'd1;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_d = cnt_q + 8'd1;
            acc_d = win_data;
            idx_d = win_idx;
            if (cnt_q == LAST) begin
              res_d     = win_data;
              res_idx_d = win_idx;
              ovalid_d  = 1'b1;
              state_d   = DONE;
            end
          end
        end
        DONE: begin
          if (ovalid_q && out_ready) begin
            ovalid_d = 1'b0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      res_q     <= '0;
      res_idx_q <= '0;
      ovalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      res_q     <= res_d;
      res_idx_q <= res_idx_d;
      ovalid_q  <= ovalid_d;
    end
  end

  assign out_valid  = ovalid_q;
  assign result     = res_q;
  assign result_idx = res_idx_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mms_stream_sel.sv
// tb_mms_stream_sel: directed bench for mms_stream_sel.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_mms_stream_sel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       select;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mms_stream_sel #(.WIDTH(8), .FRAME_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_idx (result_idx),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    select   = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic frame4(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input logic s);
    push(a, s);
    push(b, s);
    push(c, s);
    push(d, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0",
               out_valid, busy);
    end
    checks++;
    if (result !== 8'd0 || result_idx !== 8'd0) begin
      errors++;
      $display("FAIL reset_result: got %0d/%0d want 0/0",
               result, result_idx);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_max_frame();
    out_ready = 1'b1;
    frame4(8'd12, 8'd200, 8'd7, 8'd200, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL max_done: ov=%b ir=%b busy=%b want 1 0 1",
               out_valid, in_ready, busy);
    end
    checks++;
    if (result !== 8'd200 || result_idx !== 8'd1) begin
      errors++;
      $display("FAIL max_result: got %0d/%0d want 200/1",
               result, result_idx);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL max_release: ov=%b busy=%b ir=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
    checks++;
    if (result !== 8'd200 || result_idx !== 8'd1) begin
      errors++;
      $display("FAIL max_hold: got %0d/%0d want 200/1",
               result, result_idx);
    end
  endtask

  task automatic test_min_stall();
    out_ready = 1'b0;
    push(8'd9, 1'b1);
    step();
    push(8'd3, 1'b1);
    step();
    step();
    push(8'd250, 1'b1);
    push(8'd3, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'd3 || result_idx !== 8'd1) begin
      errors++;
      $display("FAIL min_result: ov=%b got %0d/%0d want 1 3/1",
               out_valid, result, result_idx);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd0;
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          result !== 8'd3 || result_idx !== 8'd1) begin
        errors++;
        $display("FAIL min_stall[%0d]: ir=%b ov=%b got %0d/%0d want 0 1 3/1",
                 i, in_ready, out_valid, result, result_idx);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL min_release: ov=%b busy=%b want 0 0",
               out_valid, busy);
    end
  endtask

  task automatic test_select_once();
    out_ready = 1'b1;
    push(8'd5, 1'b0);
    push(8'd1, 1'b1);
    push(8'd0, 1'b1);
    push(8'd255, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'd255 || result_idx !== 8'd3) begin
      errors++;
      $display("FAIL select_once: ov=%b got %0d/%0d want 1 255/3",
               out_valid, result, result_idx);
    end
    select = 1'b0;
    step();
  endtask

  task automatic test_boundaries();
    logic [7:0] exp_r [4];
    logic [7:0] exp_i [4];
    out_ready = 1'b1;
    exp_r[0] = 8'd0;   exp_i[0] = 8'd0;
    exp_r[1] = 8'd255; exp_i[1] = 8'd0;
    exp_r[2] = 8'd0;   exp_i[2] = 8'd1;
    exp_r[3] = 8'd255; exp_i[3] = 8'd1;
    for (int k = 0; k < 4; k++) begin
      unique case (k)
        0: frame4(8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        1: frame4(8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        2: frame4(8'd255, 8'd0, 8'd255, 8'd0, 1'b1);
        default: frame4(8'd0, 8'd255, 8'd0, 8'd255, 1'b0);
      endcase
      checks++;
      if (out_valid !== 1'b1 || result !== exp_r[k] ||
          result_idx !== exp_i[k]) begin
        errors++;
        $display("FAIL boundary[%0d]: ov=%b got %0d/%0d want 1 %0d/%0d",
                 k, out_valid, result, result_idx, exp_r[k], exp_i[k]);
      end
      step();
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    push(8'd50, 1'b0);
    push(8'd60, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 ||
        result !== 8'd255 || result_idx !== 8'd1) begin
      errors++;
      $display("FAIL clear_mid: busy=%b ov=%b got %0d/%0d want 0 0 255/1",
               busy, out_valid, result, result_idx);
    end
    frame4(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'd4 || result_idx !== 8'd3) begin
      errors++;
      $display("FAIL clear_fresh: ov=%b got %0d/%0d want 1 4/3",
               out_valid, result, result_idx);
    end
    step();
    out_ready = 1'b0;
    frame4(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        result !== 8'd40 || result_idx !== 8'd3) begin
      errors++;
      $display("FAIL clear_done: ov=%b busy=%b ir=%b got %0d/%0d want 0 0 1 40/3",
               out_valid, busy, in_ready, result, result_idx);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    push(8'd7, 1'b0);
    push(8'd8, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== 8'd0 || result_idx !== 8'd0) begin
      errors++;
      $display("FAIL arst_mid: ov=%b busy=%b got %0d/%0d want 0 0 0/0",
               out_valid, busy, result, result_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    frame4(8'd3, 8'd9, 8'd1, 8'd2, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'd9 || result_idx !== 8'd1) begin
      errors++;
      $display("FAIL arst_next_max: ov=%b got %0d/%0d want 1 9/1",
               out_valid, result, result_idx);
    end
    step();
    out_ready = 1'b0;
    frame4(8'd60, 8'd70, 8'd80, 8'd90, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== 8'd0 || result_idx !== 8'd0) begin
      errors++;
      $display("FAIL arst_done: ov=%b busy=%b got %0d/%0d want 0 0 0/0",
               out_valid, busy, result, result_idx);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    frame4(8'd4, 8'd2, 8'd6, 8'd2, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'd2 || result_idx !== 8'd1) begin
      errors++;
      $display("FAIL arst_next_min: ov=%b got %0d/%0d want 1 2/1",
               out_valid, result, result_idx);
    end
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    select    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    test_reset();
    test_max_frame();
    test_min_stall();
    test_select_once();
    test_boundaries();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
